is_rf_pipe: RTL

- Parametrised issue-to-register-file pipeline stage. Holds one instruction package per functional-unit channel between the issue queue and the register-file read stage.
- Generalises the fixed four-channel stage in three ways:
  - configurable channel count, package width and ROB index width;
  - per-channel selection of multi-cycle (done-gated) or single-cycle (stall-gated) capture;
  - wrap-correct ROB age flush that clears stored entries and filters incoming ones, and reports discarded in-flight multi-cycle work through a kill pulse.

---
 rtl/is_rf_pipe_if.sv | 28 ++
 rtl/is_rf_pipe.sv | 81 ++++++++
 2 files changed

// File: rtl/is_rf_pipe_if.sv
// Issue-to-RF stage bus: control strobes, per-channel packages and per-channel status.
interface is_rf_pipe_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PKG_W  = 66,
  parameter int unsigned ROB_W  = 6
);
  logic                    stall;
  logic                    mis_pred;
  logic [ROB_W-1:0]        mis_pred_indx;
  logic [ROB_W-1:0]        rob_head;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH*PKG_W-1:0] pkg_in;
  logic [NUM_CH*PKG_W-1:0] pkg_out;
  logic [NUM_CH-1:0]       fu_rdy;
  logic [NUM_CH-1:0]       kill;

  // Issue/control side.
  modport master (
    output stall, mis_pred, mis_pred_indx, rob_head, done, pkg_in,
    input  pkg_out, fu_rdy, kill
  );

  // Pipeline stage side.
  modport slave (
    input  stall, mis_pred, mis_pred_indx, rob_head, done, pkg_in,
    output pkg_out, fu_rdy, kill
  );
endinterface

// File: rtl/is_rf_pipe.sv
// Issue-to-register-file pipeline stage: one package register per functional-unit channel,
// with single-cycle (stall-gated) or multi-cycle (done-gated) capture and ROB-age flushing.
module is_rf_pipe #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       PKG_W      = 66,
  parameter int unsigned       ROB_W      = 6,
  parameter int unsigned       ROB_LSB    = 59,
  parameter logic [NUM_CH-1:0] MULTI_MASK = 4'b0001,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = 4'b1101
) (
  input logic         clk,
  input logic         rst,
  is_rf_pipe_if.slave bus
);

  logic [NUM_CH-1:0][PKG_W-1:0] pkg_in_ch;
  logic [NUM_CH-1:0][PKG_W-1:0] pkg_out_ch;
  logic [NUM_CH-1:0][PKG_W-1:0] pkg_q, pkg_d;
  logic [NUM_CH-1:0]            wen;
  logic [NUM_CH-1:0]            flush_q;
  logic [NUM_CH-1:0]            flush_in;
  logic [NUM_CH-1:0]            kill_q, kill_d;

  // Ages are taken relative to the ROB head so the compare stays correct across index wrap.
  function automatic logic younger(input logic [ROB_W-1:0] idx,
                                   input logic [ROB_W-1:0] head,
                                   input logic [ROB_W-1:0] br);
    logic [ROB_W-1:0] age_idx;
    logic [ROB_W-1:0] age_br;
    age_idx = idx - head;
    age_br  = br - head;
    return age_idx > age_br;
  endfunction

  // Channel i occupies bits [i*PKG_W +: PKG_W] of the flat buses.
  assign pkg_in_ch   = bus.pkg_in;
  assign bus.pkg_out = pkg_out_ch;
  assign bus.fu_rdy  = wen;
  assign bus.kill    = kill_q;

  // Capture enables, flush terms, masked outputs and next-state per channel.
  always_comb begin
    wen        = '0;
    flush_q    = '0;
    flush_in   = '0;
    pkg_d      = pkg_q;
    pkg_out_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (MULTI_MASK[i]) begin
        wen[i] = ~pkg_q[i][PKG_W-1] | bus.done[i];
      end else begin
        wen[i] = ~bus.stall;
      end
      flush_q[i]  = bus.mis_pred & FLUSH_MASK[i] & pkg_q[i][PKG_W-1] &
                    younger(pkg_q[i][ROB_LSB +: ROB_W], bus.rob_head, bus.mis_pred_indx);
      flush_in[i] = bus.mis_pred & FLUSH_MASK[i] & pkg_in_ch[i][PKG_W-1] &
                    younger(pkg_in_ch[i][ROB_LSB +: ROB_W], bus.rob_head, bus.mis_pred_indx);
      pkg_out_ch[i] = flush_q[i] ? '0 : pkg_q[i];
      // A write takes priority over the flush clear; the flushed entry is simply replaced.
      if (wen[i]) begin
        pkg_d[i] = flush_in[i] ? '0 : pkg_in_ch[i];
      end else if (flush_q[i]) begin
        pkg_d[i] = '0;
      end
    end
    // Only a drop without replacement means the FU must abandon in-flight work.
    kill_d = flush_q & ~wen;
  end

  // Package registers and registered kill pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkg_q  <= '0;
      kill_q <= '0;
    end else begin
      pkg_q  <= pkg_d;
      kill_q <= kill_d;
    end
  end

endmodule
